// File: rtl/regfile_sb.sv
// regfile_sb: byte-writable register file with same-cycle write bypass,
// a per-register pending scoreboard and a sequenced bulk-clear engine.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rf_w,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   raddr1,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  input  logic                busy_set,
  input  logic [ADDR_W-1:0]   busy_addr,
  output logic                busy1,
  output logic                busy2,
  input  logic                clr_req,
  output logic                clr_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned NBYTE = DATA_W/8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [ADDR_W-1:0]        cnt;
  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         pend;
  logic [DATA_W-1:0]        wmerged;
  logic                     we;
  logic                     bs;
  logic                     byp1, byp2;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_REG && (a == '0));
  endfunction

  // Qualified write / scoreboard-set strobes; both are suppressed while clearing.
  always_comb begin
    we = rf_w && (state == IDLE) && writable(waddr);
    bs = busy_set && (state == IDLE) && writable(busy_addr);
  end

  // Stored word at waddr with the enabled bytes replaced by wdata.
  always_comb begin
    wmerged = regs[waddr];
    for (int unsigned k = 0; k < NBYTE; k++) begin
      if (wbe[k]) wmerged[k*8 +: 8] = wdata[k*8 +: 8];
    end
  end

  // Combinational read ports with same-cycle bypass and zero-register masking.
  always_comb begin
    byp1   = we && (raddr1 == waddr);
    byp2   = we && (raddr2 == waddr);
    rdata1 = byp1 ? wmerged : regs[raddr1];
    rdata2 = byp2 ? wmerged : regs[raddr2];
    if (!writable(raddr1)) rdata1 = '0;
    if (!writable(raddr2)) rdata2 = '0;
    busy1  = pend[raddr1] && !byp1 && writable(raddr1);
    busy2  = pend[raddr2] && !byp2 && writable(raddr2);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; CLEAR lasts exactly DEPTH cycles, ending with cnt at DEPTH-1.
  always_comb begin
    state_next = state;
    clr_busy   = 1'b0;
    case (state)
      IDLE:  if (clr_req) state_next = CLEAR;
      CLEAR: begin
        clr_busy = 1'b1;
        if (cnt == ADDR_W'(DEPTH-1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear sweep counter; its wrap to 0 lines up with the exit from CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (state == CLEAR)            cnt <= cnt + 1'b1;
    else if (clr_req)                   cnt <= '0;
  end

  // Register array: byte-merged writes in IDLE, one entry zeroed per cycle in CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (we) begin
      regs[waddr] <= wmerged;
    end
  end

  // Scoreboard: a write retires the pending flag, a set issued the same cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else if (state == CLEAR) begin
      pend[cnt] <= 1'b0;
    end else begin
      if (we) pend[waddr]     <= 1'b0;
      if (bs) pend[busy_addr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed tests for regfile_sb at default and 64x8 parameters.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;

  logic        rf_w, busy_set, clr_req;
  logic [4:0]  waddr, raddr1, raddr2, busy_addr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2, clr_busy;

  logic        w_rf_w, w_busy_set, w_clr_req;
  logic [2:0]  w_waddr, w_raddr1, w_raddr2, w_busy_addr;
  logic [63:0] w_wdata;
  logic [7:0]  w_wbe;
  logic [63:0] w_rdata1, w_rdata2;
  logic        w_busy1, w_busy2, w_clr_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .rf_w(rf_w), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy1(busy1), .busy2(busy2),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_sb #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1'b1)) dut64 (
    .clk(clk), .reset(reset), .rf_w(w_rf_w), .waddr(w_waddr), .wdata(w_wdata), .wbe(w_wbe),
    .raddr1(w_raddr1), .raddr2(w_raddr2), .rdata1(w_rdata1), .rdata2(w_rdata2),
    .busy_set(w_busy_set), .busy_addr(w_busy_addr), .busy1(w_busy1), .busy2(w_busy2),
    .clr_req(w_clr_req), .clr_busy(w_clr_busy)
  );

  // Advance to the next falling edge, then let the design settle before checks.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rf_w = 0; busy_set = 0; clr_req = 0; waddr = 0; wdata = 0; wbe = 0;
    raddr1 = 0; raddr2 = 0; busy_addr = 0;
    w_rf_w = 0; w_busy_set = 0; w_clr_req = 0; w_waddr = 0; w_wdata = 0; w_wbe = 0;
    w_raddr1 = 0; w_raddr2 = 0; w_busy_addr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    raddr1 = 5; raddr2 = 31;
    #3;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
    total++; if ({busy1, busy2} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", {busy1, busy2}); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    rf_w = 1; waddr = 5; wdata = 32'hDEADBEEF; wbe = 4'b1111;
    step();
    rf_w = 0; raddr1 = 5;
    #1;
    total++; if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_r5 got=%h exp=deadbeef", rdata1); end
    rf_w = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr1 = 0;
    #1;
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL r0_bypass got=%h exp=0", rdata1); end
    step();
    rf_w = 0;
    #1;
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL r0_stored got=%h exp=0", rdata1); end
  endtask

  task automatic test_byte_merge();
    rf_w = 1; waddr = 7; wdata = 32'h11223344; wbe = 4'b1111;
    step();
    wdata = 32'hAABBCCDD; wbe = 4'b0101; raddr2 = 7;
    #1;
    total++; if (rdata2 !== 32'h11BB33DD) begin bad++; $display("FAIL merge_bypass got=%h exp=11bb33dd", rdata2); end
    step();
    wdata = 32'h55555555; wbe = 4'b0000;
    #1;
    total++; if (rdata2 !== 32'h11BB33DD) begin bad++; $display("FAIL wbe0_bypass got=%h exp=11bb33dd", rdata2); end
    step();
    rf_w = 0;
    #1;
    total++; if (rdata2 !== 32'h11BB33DD) begin bad++; $display("FAIL merge_stored got=%h exp=11bb33dd", rdata2); end
  endtask

  task automatic test_scoreboard();
    busy_set = 1; busy_addr = 9;
    step();
    busy_set = 0; raddr1 = 9; raddr2 = 9;
    #1;
    total++; if ({busy1, busy2} !== 2'b11) begin bad++; $display("FAIL sb_set got=%b exp=11", {busy1, busy2}); end
    rf_w = 1; waddr = 9; wdata = 32'h99; wbe = 4'b0000;
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sb_write_mask got=%b exp=0", busy1); end
    step();
    rf_w = 0;
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b exp=0", busy1); end
    rf_w = 1; busy_set = 1; busy_addr = 9;
    step();
    rf_w = 0; busy_set = 0;
    #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b exp=1", busy1); end
    busy_set = 1; busy_addr = 0;
    step();
    busy_set = 0; raddr2 = 0;
    #1;
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL sb_r0 got=%b exp=0", busy2); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 1; i < 32; i++) begin
      rf_w = 1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101; wbe = 4'b1111;
      busy_set = 1; busy_addr = 5'(i);
      step();
    end
    rf_w = 0; busy_set = 0;
    clr_req = 1;
    step();
    clr_req = 0;
    rf_w = 1; waddr = 4; wdata = 32'hCAFEF00D; wbe = 4'b1111;
    busy_set = 1; busy_addr = 2;
    raddr1 = 4; raddr2 = 20;
    #1;
    total++; if (rdata1 !== 32'h04040404) begin bad++; $display("FAIL clr_no_bypass got=%h exp=04040404", rdata1); end
    total++; if (rdata2 !== 32'h14141414) begin bad++; $display("FAIL clr_not_yet got=%h exp=14141414", rdata2); end
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      n++;
      if (n == 16) clr_req = 1;
      else         clr_req = 0;
      step();
    end
    rf_w = 0; busy_set = 0; clr_req = 0;
    #1;
    total++; if (n !== 32) begin bad++; $display("FAIL clr_cycles got=%0d exp=32", n); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL clr_exit got=%b exp=0", clr_busy); end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      total++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
        bad++;
        $display("FAIL clr_contents a=%0d got=%h/%h busy=%b%b exp=0/0 busy=00", i, rdata1, rdata2, busy1, busy2);
      end
    end
    step();
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL clr_no_retrigger got=%b exp=0", clr_busy); end
  endtask

  task automatic test_reset_mid_clear();
    rf_w = 1; waddr = 20; wdata = 32'h20202020; wbe = 4'b1111;
    step();
    rf_w = 0; clr_req = 1;
    step();
    clr_req = 0;
    repeat (9) step();
    raddr1 = 20;
    #1;
    total++; if (rdata1 !== 32'h20202020) begin bad++; $display("FAIL mid_before got=%h exp=20202020", rdata1); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL mid_abort got=%b exp=0", clr_busy); end
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL mid_regs got=%h exp=0", rdata1); end
    step();
    reset = 1'b0;
    rf_w = 1; waddr = 3; wdata = 32'h12345678; wbe = 4'b1111;
    step();
    rf_w = 0; raddr1 = 3;
    #1;
    total++; if (rdata1 !== 32'h12345678 || clr_busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_r3 got=%h clr=%b exp=12345678 clr=0", rdata1, clr_busy);
    end
  endtask

  task automatic test_param64();
    int n;
    w_rf_w = 1; w_waddr = 2; w_wdata = 64'h0123456789ABCDEF; w_wbe = 8'hFF;
    step();
    w_wdata = 64'hFFEEDDCCBBAA9988; w_wbe = 8'b10100101; w_raddr1 = 2;
    #1;
    total++; if (w_rdata1 !== 64'hFF23DD6789AACD88) begin bad++; $display("FAIL w64_bypass got=%h exp=ff23dd6789aacd88", w_rdata1); end
    step();
    w_rf_w = 0;
    #1;
    total++; if (w_rdata1 !== 64'hFF23DD6789AACD88) begin bad++; $display("FAIL w64_stored got=%h exp=ff23dd6789aacd88", w_rdata1); end
    w_busy_set = 1; w_busy_addr = 7;
    step();
    w_busy_set = 0; w_raddr2 = 7;
    #1;
    total++; if (w_busy2 !== 1'b1) begin bad++; $display("FAIL w64_busy got=%b exp=1", w_busy2); end
    w_clr_req = 1;
    step();
    w_clr_req = 0;
    n = 0;
    while (w_clr_busy === 1'b1 && n < 20) begin
      n++;
      step();
    end
    total++; if (n !== 8) begin bad++; $display("FAIL w64_clr_cycles got=%0d exp=8", n); end
    total++; if (w_rdata1 !== 64'h0 || w_busy2 !== 1'b0) begin
      bad++; $display("FAIL w64_cleared got=%h busy=%b exp=0 busy=0", w_rdata1, w_busy2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_merge();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_param64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 SHALL read as 0 and never be written or marked pending.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rf_w  input  1  write enable.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 wbe  input  DATA_W/8  byte enables for the write.
REQ-010 raddr1, raddr2  input  ADDR_W  read addresses.
REQ-011 rdata1, rdata2  output  DATA_W  read data.
REQ-012 busy_set  input  1  mark register busy_addr pending (producer issued).
REQ-013 busy_addr  input  ADDR_W  scoreboard set address.
REQ-014 busy1, busy2  output  1  pending flag for raddr1/raddr2.
REQ-015 clr_req  input  1  start bulk-clear sequence (1-cycle pulse).
REQ-016 clr_busy  output  1  bulk clear in progress.

Function
REQ-017 Write: when rf_w=1, not in CLEAR, waddr writable, each byte k with wbe[k]=1 SHALL take wdata byte k at the rising edge; other bytes SHALL hold.
REQ-018 Reads SHALL be combinational, zero-latency.
REQ-019 Bypass: if rf_w=1, not in CLEAR, raddrN==waddr and waddr writable, rdataN SHALL be the stored word with wbe-selected bytes replaced by wdata in the same cycle.
REQ-020 Scoreboard: pend[i] SHALL set on busy_set at busy_addr=i; SHALL clear on rf_w write to i (any wbe, including all-zero).
REQ-021 Simultaneous busy_set and rf_w to same address: set SHALL win (pend=1 next cycle).
REQ-022 busyN SHALL equal pend[raddrN] AND NOT(rf_w write to raddrN this cycle); with ZERO_REG=1, busyN=0 for address 0.
REQ-023 FSM states IDLE, CLEAR; IDLE->CLEAR on clr_req=1; counter cnt loads 0.
REQ-024 In CLEAR each cycle register cnt SHALL be zeroed and pend[cnt] cleared, cnt incremented; after cnt=DEPTH-1 FSM SHALL return to IDLE (exactly DEPTH cycles in CLEAR).
REQ-025 clr_busy SHALL be 1 exactly while in CLEAR.
REQ-026 In CLEAR, rf_w, busy_set and clr_req SHALL be ignored; bypass disabled; reads return stored contents (already-cleared entries read 0).
REQ-027 cnt SHALL be ADDR_W bits wide; wrap from DEPTH-1 to 0 coincides with CLEAR->IDLE exit.

Reset
REQ-028 reset=1 SHALL immediately, independent of clk, zero all registers, all pend bits, cnt, and force IDLE; clr_busy=0, busy1=busy2=0, rdata reflects zeros.
REQ-029 reset asserted mid-CLEAR SHALL abort the sequence; after deassertion FSM is IDLE.

Verification
REQ-030 Reset, write 0xDEADBEEF to r5 wbe=1111, read raddr1=5 next cycle -> rdata1=0xDEADBEEF; rf_w to r0 with 0xFFFFFFFF -> rdata=0 (ZERO_REG=1).
REQ-031 r7=0x11223344, write wbe=0101 wdata=0xAABBCCDD -> same-cycle rdata2=0x11BB33DD (bypass), next cycle stored 0x11BB33DD.
REQ-032 busy_set r9 -> busy1=1 at raddr1=9 next cycle; rf_w r9 same cycle busy1=0; next cycle pend cleared; busy_set+rf_w r9 together -> pend=1 after edge.
REQ-033 Fill r1..r31, pulse clr_req -> clr_busy=1 for 32 cycles, rf_w during CLEAR has no effect, after exit all reads 0 and all busy 0.
REQ-034 Start CLEAR, assert reset at cycle 10 -> clr_busy=0 immediately, all registers 0, subsequent write/read to r3 works normally.
REQ-035 Parameter sweep DATA_W=64, ADDR_W=3: byte-enable merge, bypass and 8-cycle CLEAR per REQ-017..REQ-027.
